pwm_duty_controller: RTL and testbench



---
 rtl/pwm_duty_if.sv | 23 ++
 rtl/pwm_duty_controller.sv | 160 ++++++++++++++++
 tb/tb_pwm_duty_controller.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_if.sv
// Button/period inputs and duty outputs between the UI front-end and the PWM duty controller.
// Signalling: inc_btn/dec_btn are raw asynchronous levels; period_end and step_pulse are 1-cycle pulses.
interface pwm_duty_if #(
  parameter int DUTY_W = 4
);
  logic              inc_btn;
  logic              dec_btn;
  logic              period_end;
  logic [DUTY_W-1:0] duty;
  logic              duty_pending;
  logic              step_pulse;
  logic [2:0]        fsm_state;

  modport master (
    output inc_btn, dec_btn, period_end,
    input  duty, duty_pending, step_pulse, fsm_state
  );

  modport slave (
    input  inc_btn, dec_btn, period_end,
    output duty, duty_pending, step_pulse, fsm_state
  );
endinterface

// File: rtl/pwm_duty_controller.sv
// Push-button duty setpoint controller: sync, debounce, step/auto-repeat with saturation,
// and a shadow duty register that only updates on PWM period boundaries.
module pwm_duty_controller #(
  parameter int DUTY_W        = 4,
  parameter int DUTY_MAX      = 10,
  parameter int DUTY_RST      = 5,
  parameter int DEB_CYCLES    = 4,
  parameter int HOLD_CYCLES   = 16,
  parameter int REPEAT_CYCLES = 8
) (
  input logic        clk,
  input logic        rst,
  pwm_duty_if.slave  bus
);

  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int RPT_W  = $clog2(REPEAT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STEP   = 3'd1,
    HOLD   = 3'd2,
    REPEAT = 3'd3,
    LOCK   = 3'd4
  } state_t;

  logic              inc_m, dec_m, inc_s, dec_s;
  logic [1:0]        raw, cand, deb;
  logic [DEB_W-1:0]  deb_cnt;
  state_t            state, state_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [RPT_W-1:0]  rpt_cnt, rpt_n;
  logic [1:0]        held, held_n;
  logic              step_up, step_dn;
  logic [DUTY_W-1:0] target, duty_r;
  logic              pulse_r;
  logic              can_up, can_dn;

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_m <= 1'b0;
      dec_m <= 1'b0;
      inc_s <= 1'b0;
      dec_s <= 1'b0;
    end else begin
      inc_m <= bus.inc_btn;
      dec_m <= bus.dec_btn;
      inc_s <= inc_m;
      dec_s <= dec_m;
    end
  end

  assign raw = {inc_s, dec_s};

  // The mismatch edge starts the run, so a level is accepted after DEB_CYCLES further matches.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand    <= 2'b00;
      deb_cnt <= '0;
      deb     <= 2'b00;
    end else if (raw != cand) begin
      cand    <= raw;
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
      deb     <= cand;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      rpt_cnt  <= '0;
      held     <= 2'b00;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      rpt_cnt  <= rpt_n;
      held     <= held_n;
    end
  end

  // A step is applied on the edge that enters STEP, so target moves as the press is recognised.
  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    rpt_n   = rpt_cnt;
    held_n  = held;
    step_up = 1'b0;
    step_dn = 1'b0;
    case (state)
      IDLE: begin
        held_n = deb;
        case (deb)
          2'b10: begin state_n = STEP; step_up = 1'b1; end
          2'b01: begin state_n = STEP; step_dn = 1'b1; end
          2'b11: state_n = LOCK;
          default: state_n = IDLE;
        endcase
      end
      STEP: begin
        state_n = HOLD;
        hold_n  = '0;
      end
      HOLD: begin
        if (deb != held) begin
          state_n = IDLE;
        end else if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_n = REPEAT;
          rpt_n   = '0;
          step_up = held[1];
          step_dn = held[0];
        end else begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end
      REPEAT: begin
        if (deb != held) begin
          state_n = IDLE;
        end else if (rpt_cnt == RPT_W'(REPEAT_CYCLES - 1)) begin
          rpt_n   = '0;
          step_up = held[1];
          step_dn = held[0];
        end else begin
          rpt_n = rpt_cnt + RPT_W'(1);
        end
      end
      LOCK: begin
        if (deb == 2'b00) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign can_up = step_up && (target != DUTY_W'(DUTY_MAX));
  assign can_dn = step_dn && (target != '0);

  // duty samples target before this edge's step, so a coincident step waits a full period.
  always_ff @(posedge clk) begin
    if (rst) begin
      target  <= DUTY_W'(DUTY_RST);
      duty_r  <= DUTY_W'(DUTY_RST);
      pulse_r <= 1'b0;
    end else begin
      if (can_up) target <= target + DUTY_W'(1);
      else if (can_dn) target <= target - DUTY_W'(1);
      if (bus.period_end) duty_r <= target;
      pulse_r <= can_up || can_dn;
    end
  end

  assign bus.duty         = duty_r;
  assign bus.duty_pending = (target != duty_r);
  assign bus.step_pulse   = pulse_r;
  assign bus.fsm_state    = state;

endmodule

// File: tb/tb_pwm_duty_controller.sv
// Bench for pwm_duty_controller: directed scenarios plus random bouncy presses against a timeline model.
module tb_pwm_duty_controller;

  localparam int DUTY_W   = 4;
  localparam int DUTY_MAX = 10;
  localparam int DUTY_RST = 5;
  localparam int DEB      = 4;
  localparam int HOLD     = 16;
  localparam int RPT      = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pwm_duty_if #(.DUTY_W(DUTY_W)) bus ();

  pwm_duty_controller #(
    .DUTY_W(DUTY_W), .DUTY_MAX(DUTY_MAX), .DUTY_RST(DUTY_RST),
    .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected {duty, duty_pending, step_pulse} after each edge.
  logic [DUTY_W+1:0] exp_q[$];

  // Reference timeline: raw samples per edge, reset marks, press bookkeeping in edge numbers.
  logic [1:0] seen_q[$];
  bit         rst_q[$];
  int         n_edge = 0;
  logic [1:0] m_deb = 2'b00;
  int         m_mode = 0;  // 0 released, 1 pressed, 2 both-held lockout
  int         press_edge = 0;
  logic [1:0] press_code = 2'b00;
  int         m_target = DUTY_RST;
  int         m_duty = DUTY_RST;
  bit         m_pulse = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] deb_in(input int k);
    if (k < 2) return 2'b00;
    if (rst_q[k-1] || rst_q[k-2]) return 2'b00;
    return seen_q[k-2];
  endfunction

  task automatic model_edge(input logic inc, input logic dec, input logic pe, input logic r);
    int k, dir, nt, el;
    logic [1:0] c, v;
    bit all_same;
    k = n_edge;
    n_edge++;
    seen_q.push_back({inc, dec});
    rst_q.push_back(r);
    if (r) begin
      m_deb = 2'b00; m_mode = 0; m_target = DUTY_RST; m_duty = DUTY_RST; m_pulse = 1'b0;
    end else begin
      c = m_deb;
      dir = 0;
      if (m_mode == 0) begin
        if (c == 2'b10 || c == 2'b01) begin
          m_mode = 1; press_edge = k; press_code = c;
          dir = (c == 2'b10) ? 1 : -1;
        end else if (c == 2'b11) begin
          m_mode = 2;
        end
      end else if (m_mode == 1) begin
        el = k - press_edge - 1;
        if (k >= press_edge + 2 && c != press_code) m_mode = 0;
        else if (el >= HOLD && ((el - HOLD) % RPT) == 0) dir = (press_code == 2'b10) ? 1 : -1;
      end else if (c == 2'b00) begin
        m_mode = 0;
      end
      if (pe) m_duty = m_target;
      nt = m_target + dir;
      if (nt > DUTY_MAX) nt = DUTY_MAX;
      if (nt < 0) nt = 0;
      m_pulse = (nt != m_target);
      m_target = nt;
      if (k >= DEB) begin
        v = deb_in(k);
        all_same = 1'b1;
        for (int j = k - DEB; j <= k; j++) if (deb_in(j) != v) all_same = 1'b0;
        if (all_same) m_deb = v;
      end
    end
    exp_q.push_back({DUTY_W'(m_duty), m_target != m_duty, m_pulse});
  endtask

  task automatic cycle(input logic inc, input logic dec, input logic pe, input logic r);
    logic [DUTY_W+1:0] e;
    @(negedge clk);
    bus.inc_btn = inc;
    bus.dec_btn = dec;
    bus.period_end = pe;
    rst = r;
    model_edge(inc, dec, pe, r);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("duty", bus.duty, e[DUTY_W+1:2]);
    check_eq("duty_pending", bus.duty_pending, e[1]);
    check_eq("step_pulse", bus.step_pulse, e[0]);
  endtask

  task automatic do_reset(input int cyc);
    repeat (cyc) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int len, hi;
    logic [1:0] code, b;
    bus.inc_btn = 1'b0;
    bus.dec_btn = 1'b0;
    bus.period_end = 1'b0;

    // Reset and idle
    do_reset(3);
    check_eq("rst_duty", bus.duty, DUTY_RST);
    check_eq("rst_pending", bus.duty_pending, 0);
    repeat (20) cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Single clean press, applied at the next period boundary
    for (int i = 0; i < 45; i++) begin
      cycle(i < 12, 1'b0, i == 39, 1'b0);
      if (i == 7) check_eq("t2_pulse_edge7", bus.step_pulse, 1);
      if (i == 20) check_eq("t2_pending", bus.duty_pending, 1);
    end
    check_eq("t2_duty", bus.duty, 6);

    // Short bursts never pass the debouncer
    do_reset(1);
    for (int i = 0; i < 30; ) begin
      hi = $urandom_range(1, 3);
      for (int j = 0; j < hi && i < 30; j++, i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      if (i < 30) begin cycle(1'b0, 1'b0, 1'b0, 1'b0); i++; end
    end
    repeat (10) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("t3_duty", bus.duty, DUTY_RST);

    // Long hold: first step, hold delay, repeats, saturation
    do_reset(1);
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, 1'b0, (i % 10) == 9, 1'b0);
      check_eq("t4_step_time", bus.step_pulse, (i == 7 || i == 24 || i == 32 || i == 40 || i == 48));
    end
    repeat (12) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("t4_duty_max", bus.duty, DUTY_MAX);

    // Both held locks out; a later decrement press ramps down and clamps
    for (int i = 0; i < 50; i++) cycle(1'b1, 1'b1, (i % 10) == 9, 1'b0);
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, (i % 10) == 9, 1'b0);
    check_eq("t5_locked_duty", bus.duty, DUTY_MAX);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 160; i++) cycle(1'b0, 1'b1, (i % 10) == 9, 1'b0);
    repeat (12) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("t5_duty_min", bus.duty, 0);

    // Reset while auto-repeating; first new step coincides with period_end
    do_reset(1);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("t6_rst_duty", bus.duty, DUTY_RST);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b1, i == 7, 1'b0);
      if (i == 7) begin
        check_eq("t6_duty_prestep", bus.duty, DUTY_RST);
        check_eq("t6_pending", bus.duty_pending, 1);
      end
    end

    // Random bouncy presses, random period boundaries, rare resets
    for (int s = 0; s < 60; s++) begin
      code = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 70);
      for (int i = 0; i < len; i++) begin
        b = code;
        if (i < 6 && $urandom_range(0, 3) == 0) b = 2'($urandom_range(0, 3));
        cycle(b[1], b[0], $urandom_range(0, 9) == 0, $urandom_range(0, 399) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
